// File: rtl/alu4_sched.sv
// Round-robin scheduler that runs two requesters' W-bit operations through a
// shared 4-bit combinational ALU, one nibble per cycle with carry chaining.
module alu4_sched #(
  parameter int unsigned NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [1:0]         op0,
  input  logic [1:0]         op1,
  input  logic [4*NIB-1:0]   a0,
  input  logic [4*NIB-1:0]   b0,
  input  logic [4*NIB-1:0]   a1,
  input  logic [4*NIB-1:0]   b1,
  input  logic               cin0,
  input  logic               cin1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [4*NIB-1:0]   result,
  output logic               cout,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [1:0]         alu_f,
  output logic               alu_cci,
  input  logic [3:0]         alu_d,
  input  logic               alu_co
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            last;
  logic            owner;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            cin_q;
  logic            carry_q;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic [W-1:0]    res_q;
  logic            cout_q;
  logic            id_q;
  logic            pick1;
  logic            take;
  logic [KW+1:0]   shamt;

  // Grant is combinational so an IDLE-cycle request is accepted in that same
  // cycle; everything downstream of the grant comes from registered state.
  always_comb begin
    pick1 = req1 && (!req0 || !last);
    take  = (state == IDLE) && !rst && (req0 || req1);
  end

  assign gnt0    = take && !pick1;
  assign gnt1    = take && pick1;
  assign busy    = !rst && (take || (state != IDLE));
  assign done    = !rst && (state == DONE);
  assign done_id = !rst && id_q;
  assign result  = rst ? '0 : res_q;
  assign cout    = !rst && cout_q;

  assign shamt = {k, 2'b00};

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_f   = '0;
    alu_cci = 1'b0;
    if (!rst && (state == RUN)) begin
      alu_a   = 4'(a_q >> shamt);
      alu_b   = 4'(b_q >> shamt);
      alu_f   = op_q;
      alu_cci = (k == '0) ? cin_q : carry_q;
    end
  end

  // Merge the current ALU nibble into the partially assembled result.
  always_comb begin
    acc_next = (acc & ~(W'(4'hF) << shamt)) | (W'(alu_d) << shamt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      acc     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            owner <= pick1;
            last  <= pick1;
            op_q  <= pick1 ? op1  : op0;
            a_q   <= pick1 ? a1   : a0;
            b_q   <= pick1 ? b1   : b0;
            cin_q <= pick1 ? cin1 : cin0;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_q <= alu_co;
          if (k == KW'(NIB - 1)) begin
            res_q  <= acc_next;
            cout_q <= alu_co;
            id_q   <= owner;
            k      <= '0;
            state  <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
